// File: rtl/prbs_lfsr_checker_if.sv
// prbs_lfsr_checker_if
//   Carries the serial pattern stream from the generator side to the checker.
//   Signals:
//     in_valid  beat qualifier; in_bit is meaningful only while this is high
//     in_bit    received stream bit
//   Modports:
//     master    stream source (drives in_valid / in_bit)
//     slave     stream sink (the checker)
interface prbs_lfsr_checker_if;
  logic in_valid;
  logic in_bit;

  modport master (output in_valid, output in_bit);
  modport slave  (input  in_valid, input  in_bit);
endinterface

// File: rtl/prbs_lfsr_checker.sv
// prbs_lfsr_checker
//   Receive-side checker for the LFSR pattern generator. It seeds a shadow
//   LFSR from received bits. It then predicts each following bit and, once
//   enough predictions have matched, declares lock. While locked the shadow
//   runs on its own predictions, so line errors are counted without
//   corrupting the shadow. Too many consecutive misses drop lock and reseed.
//   Ports:
//     clk        rising-edge clock
//     resetn     asynchronous active-low reset
//     stream     slave side of the stream interface (in_valid, in_bit)
//     clr_err    synchronous clear of err_cnt
//     locked     registered, high while in LOCKED
//     err_pulse  one-cycle flag for a mismatch seen while LOCKED
//     err_cnt    saturating count of mismatches seen while LOCKED
//     state      00 SEED, 01 CHECK, 10 LOCKED
module prbs_lfsr_checker #(
  parameter int               WIDTH       = 3,
  parameter logic [WIDTH-1:0] TAPS        = 3'b110,
  parameter int               LOCK_CNT    = 4,
  parameter int               LOSS_THRESH = 3,
  parameter int               CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  prbs_lfsr_checker_if.slave   stream,
  input  logic                 clr_err,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [1:0]           state
);

  localparam int SEED_W  = $clog2(WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(LOSS_THRESH + 1);

  typedef enum logic [1:0] {
    SEED   = 2'b00,
    CHECK  = 2'b01,
    LOCKED = 2'b10
  } state_t;

  state_t             st;
  logic [WIDTH-1:0]   shadow;
  logic [SEED_W-1:0]  seed_cnt;
  logic [MATCH_W-1:0] match_cnt;
  logic [MISS_W-1:0]  miss_cnt;

  logic               pred;
  logic [WIDTH-1:0]   rx_shift;
  logic [WIDTH-1:0]   fly_shift;
  logic [CNT_W-1:0]   err_inc;

  // Prediction comes from the pre-shift shadow. Two candidate next shadows:
  // one takes the received bit (seeding / checking), the other takes the
  // prediction (flywheel while locked).
  always_comb begin
    pred      = ^(shadow & TAPS);
    rx_shift  = {shadow[WIDTH-2:0], stream.in_bit};
    fly_shift = {shadow[WIDTH-2:0], pred};
    err_inc   = (err_cnt == {CNT_W{1'b1}}) ? err_cnt : err_cnt + 1'b1;
  end

  assign state = st;

  // Single state machine; all outputs are registered. err_pulse defaults
  // low every cycle so it is only ever a one-cycle flag. clr_err is applied
  // first so that a mismatch on the same beat overrides it with a count of 1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st        <= SEED;
      shadow    <= '0;
      seed_cnt  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (clr_err) begin
        err_cnt <= '0;
      end
      if (stream.in_valid) begin
        case (st)
          SEED: begin
            shadow <= rx_shift;
            if (seed_cnt == SEED_W'(WIDTH - 1)) begin
              seed_cnt <= '0;
              // An all-zero shadow would predict zeros forever, so keep
              // seeding instead of moving on.
              if (rx_shift != '0) begin
                st        <= CHECK;
                match_cnt <= '0;
              end
            end else begin
              seed_cnt <= seed_cnt + 1'b1;
            end
          end

          CHECK: begin
            // The shadow keeps taking received bits, so a mismatch here
            // simply reseeds it from the stream.
            shadow <= rx_shift;
            if (stream.in_bit == pred) begin
              if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                st        <= LOCKED;
                locked    <= 1'b1;
                match_cnt <= '0;
                miss_cnt  <= '0;
              end else begin
                match_cnt <= match_cnt + 1'b1;
              end
            end else begin
              match_cnt <= '0;
            end
          end

          LOCKED: begin
            shadow <= fly_shift;
            if (stream.in_bit != pred) begin
              err_pulse <= 1'b1;
              err_cnt   <= clr_err ? CNT_W'(1) : err_inc;
              if (miss_cnt == MISS_W'(LOSS_THRESH - 1)) begin
                st        <= SEED;
                locked    <= 1'b0;
                shadow    <= '0;
                seed_cnt  <= '0;
                match_cnt <= '0;
                miss_cnt  <= '0;
              end else begin
                miss_cnt <= miss_cnt + 1'b1;
              end
            end else begin
              miss_cnt <= '0;
            end
          end

          default: begin
            st        <= SEED;
            locked    <= 1'b0;
            shadow    <= '0;
            seed_cnt  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prbs_lfsr_checker.sv
// tb_prbs_lfsr_checker
//   Scoreboard bench for prbs_lfsr_checker. The driver issues one stimulus
//   per cycle, steps a behavioural model of the checker and queues the
//   expected outputs; an independent monitor pops and compares them after
//   each rising edge. Directed checks add fixed expectations for lock
//   latency, error counting, lock loss, reset and saturation.
module tb_prbs_lfsr_checker;

  localparam int WIDTH       = 3;
  localparam int LOCK_CNT    = 4;
  localparam int LOSS_THRESH = 3;
  localparam int ERR_MAX     = 255;

  logic       clk = 1'b0;
  logic       resetn;
  logic       clr_err;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_cnt;
  logic [1:0] state;

  prbs_lfsr_checker_if sif ();

  prbs_lfsr_checker dut (
    .clk       (clk),
    .resetn    (resetn),
    .stream    (sif.slave),
    .clr_err   (clr_err),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .state     (state)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  // Generator output for seed 001, period 7.
  bit pat [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  int ph = 0;

  // Behavioural model: history of received/flywheel bits (index 0 newest),
  // a mode number and plain integer counters.
  logic [2:0] tapMask = 3'b110;
  bit  mHist [$];
  int  mMode;
  int  mSeed, mMatch, mMiss, mErr;
  bit  mPulse;

  typedef struct {
    bit lk;
    bit pu;
    int er;
    int st;
    int beat;
  } exp_t;

  exp_t scq [$];
  int   beatNo = 0;

  task automatic modelReset();
    mMode  = 0;
    mSeed  = 0;
    mMatch = 0;
    mMiss  = 0;
    mErr   = 0;
    mPulse = 1'b0;
    mHist.delete();
    for (int i = 0; i < WIDTH; i++) mHist.push_back(1'b0);
  endtask

  function automatic bit modelPredict();
    int ones = 0;
    for (int j = 0; j < WIDTH; j++)
      if (tapMask[j]) ones += int'(mHist[j]);
    return bit'(ones % 2);
  endfunction

  function automatic int modelOnes();
    int ones = 0;
    for (int j = 0; j < WIDTH; j++) ones += int'(mHist[j]);
    return ones;
  endfunction

  task automatic modelPush(input bit b);
    mHist.push_front(b);
    mHist.delete(WIDTH);
  endtask

  task automatic modelStep(input bit v, input bit b, input bit clr);
    bit p;
    mPulse = 1'b0;
    if (clr) mErr = 0;
    if (v) begin
      p = modelPredict();
      if (mMode == 0) begin
        modelPush(b);
        mSeed++;
        if (mSeed == WIDTH) begin
          mSeed = 0;
          if (modelOnes() != 0) begin
            mMode  = 1;
            mMatch = 0;
          end
        end
      end else if (mMode == 1) begin
        modelPush(b);
        if (b == p) begin
          mMatch++;
          if (mMatch == LOCK_CNT) begin
            mMode = 2;
            mMatch = 0;
            mMiss = 0;
          end
        end else begin
          mMatch = 0;
        end
      end else begin
        modelPush(p);
        if (b != p) begin
          mPulse = 1'b1;
          mErr   = clr ? 1 : ((mErr < ERR_MAX) ? mErr + 1 : ERR_MAX);
          mMiss++;
          if (mMiss == LOSS_THRESH) begin
            mMode = 0;
            mSeed = 0;
            mMatch = 0;
            mMiss = 0;
            for (int j = 0; j < WIDTH; j++) mHist[j] = 1'b0;
          end
        end else begin
          mMiss = 0;
        end
      end
    end
  endtask

  // Drive one cycle of stimulus and queue what the DUT should show after
  // the following rising edge.
  task automatic applyStimulus(input logic v, input logic b, input logic clr);
    exp_t e;
    @(negedge clk);
    sif.in_valid = v;
    sif.in_bit   = b;
    clr_err      = clr;
    modelStep(v, b, clr);
    beatNo++;
    e.lk   = (mMode == 2);
    e.pu   = mPulse;
    e.er   = mErr;
    e.st   = mMode;
    e.beat = beatNo;
    scq.push_back(e);
  endtask

  task automatic sendClean();
    applyStimulus(1'b1, pat[ph], 1'b0);
    ph = (ph + 1) % 7;
  endtask

  task automatic sendError(input bit clr);
    bit flipped;
    flipped = ~pat[ph];
    applyStimulus(1'b1, flipped, clr);
    ph = (ph + 1) % 7;
  endtask

  task automatic sendIdle();
    bit junk;
    junk = 1'($urandom);
    applyStimulus(1'b0, junk, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic checkNow(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    nChecks++;
    if (locked !== e.lk || err_pulse !== e.pu || int'(err_cnt) != e.er || int'(state) != e.st) begin
      nFails++;
      $display("[TB] FAIL scoreboard beat %0d: got locked=%0b err_pulse=%0b err_cnt=%0d state=%0d, expected locked=%0b err_pulse=%0b err_cnt=%0d state=%0d",
               e.beat, locked, err_pulse, err_cnt, state, e.lk, e.pu, e.er, e.st);
    end
  endtask

  // Monitor: one expectation per cycle, compared just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (scq.size() > 0) checkOutput(scq.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetn       = 1'b0;
    clr_err      = 1'b0;
    sif.in_valid = 1'b0;
    sif.in_bit   = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #2;
    checkNow("reset locked", int'(locked), 0);
    checkNow("reset err_pulse", int'(err_pulse), 0);
    checkNow("reset err_cnt", int'(err_cnt), 0);
    checkNow("reset state", int'(state), 0);
    @(negedge clk);
    resetn = 1'b1;

    $display("[TB] clean stream lock");
    for (int i = 1; i <= 7; i++) begin
      sendClean();
      settle();
      checkNow("t1 locked", int'(locked), (i == 7) ? 1 : 0);
      checkNow("t1 state", int'(state), (i < 3) ? 0 : ((i < 7) ? 1 : 2));
    end
    repeat (43) sendClean();
    settle();
    checkNow("t1 err_cnt after 50 beats", int'(err_cnt), 0);
    checkNow("t1 still locked", int'(locked), 1);

    $display("[TB] single bit error");
    sendError(1'b0);
    settle();
    checkNow("t2 err_pulse", int'(err_pulse), 1);
    checkNow("t2 err_cnt", int'(err_cnt), 1);
    checkNow("t2 locked", int'(locked), 1);
    repeat (20) sendClean();
    settle();
    checkNow("t2 err_cnt after clean", int'(err_cnt), 1);
    checkNow("t2 err_pulse after clean", int'(err_pulse), 0);

    $display("[TB] burst of three errors");
    applyStimulus(1'b1, pat[ph], 1'b1);
    ph = (ph + 1) % 7;
    settle();
    checkNow("t3 clr_err", int'(err_cnt), 0);
    for (int i = 1; i <= 3; i++) begin
      sendError(1'b0);
      settle();
      checkNow("t3 locked", int'(locked), (i < 3) ? 1 : 0);
    end
    checkNow("t3 err_cnt", int'(err_cnt), 3);
    checkNow("t3 state", int'(state), 0);
    for (int i = 1; i <= 7; i++) begin
      sendClean();
      settle();
      checkNow("t3 relock", int'(locked), (i == 7) ? 1 : 0);
    end

    $display("[TB] reset mid-lock");
    for (int i = 0; i < 5; i++) begin
      sendError(1'b0);
      sendClean();
    end
    settle();
    checkNow("t6 err_cnt before reset", int'(err_cnt), 8);
    applyStimulus(1'b1, pat[ph], 1'b1);
    ph = (ph + 1) % 7;
    for (int i = 0; i < 5; i++) begin
      sendError(1'b0);
      sendClean();
    end
    settle();
    checkNow("t6 err_cnt five", int'(err_cnt), 5);
    @(negedge clk);
    sif.in_valid = 1'b0;
    resetn = 1'b0;
    modelReset();
    #1;
    checkNow("t6 reset locked", int'(locked), 0);
    checkNow("t6 reset err_cnt", int'(err_cnt), 0);
    checkNow("t6 reset state", int'(state), 0);
    @(negedge clk);
    resetn = 1'b1;

    $display("[TB] all-zero input");
    repeat (30) applyStimulus(1'b1, 1'b0, 1'b0);
    settle();
    checkNow("t4 state", int'(state), 0);
    checkNow("t4 locked", int'(locked), 0);
    checkNow("t4 err_cnt", int'(err_cnt), 0);

    $display("[TB] stalled stream");
    for (int i = 1; i <= 7; i++) begin
      sendClean();
      settle();
      checkNow("t5 locked", int'(locked), (i == 7) ? 1 : 0);
      sendIdle();
      settle();
      checkNow("t5 idle err_pulse", int'(err_pulse), 0);
    end

    $display("[TB] clr_err with mismatch");
    sendError(1'b0);
    sendClean();
    sendError(1'b0);
    sendClean();
    settle();
    checkNow("t6 err_cnt two", int'(err_cnt), 2);
    sendError(1'b1);
    settle();
    checkNow("t6 clr with mismatch", int'(err_cnt), 1);
    sendClean();

    $display("[TB] saturation");
    for (int i = 0; i < 300; i++) begin
      sendError(1'b0);
      sendClean();
    end
    settle();
    checkNow("t6 saturated err_cnt", int'(err_cnt), ERR_MAX);
    checkNow("t6 locked after saturation", int'(locked), 1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      bit v, b, clr;
      int r;
      v   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 19) == 0);
      r   = $urandom_range(0, 99);
      if (!v) begin
        b = 1'($urandom);
      end else if (i < 100) begin
        b = 1'($urandom);
      end else begin
        b = (r < 8) ? ~pat[ph] : pat[ph];
      end
      applyStimulus(v, b, clr);
      if (v) ph = (ph + 1) % 7;
    end

    settle();
    settle();
    checkNow("scoreboard drained", scq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
